// File: rtl/inst_rom_loader.sv
// Boot-loaded instruction ROM for the riscv fetch port: assembles a little-endian byte
// stream into 32-bit words, holds the core in reset while loading, then serves fetches.
module inst_rom_loader #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rom_ce_i,
  input  logic [31:0]   rom_addr_i,
  output logic [31:0]   rom_data_o,
  input  logic          ld_valid_i,
  input  logic [7:0]    ld_byte_i,
  input  logic          ld_last_i,
  output logic          ld_ready_o,
  output logic          core_rst_n_o,
  output logic          load_done_o,
  output logic          ovf_o,
  output logic [AW:0]   words_o
);

  localparam logic [1:0]  ST_LOAD    = 2'd0;
  localparam logic [1:0]  ST_COMMIT  = 2'd1;
  localparam logic [1:0]  ST_RUN     = 2'd2;
  localparam logic [AW:0] DEPTH_W    = (AW+1)'(DEPTH);
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

  logic [1:0]  state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [AW:0] word_idx_q, word_idx_d;
  logic [23:0] shift_q, shift_d;
  logic        core_rst_n_q, core_rst_n_d;
  logic        load_done_q, load_done_d;
  logic        ovf_q, ovf_d;

  logic        accept;
  logic        word_wr;
  logic        mem_we;
  logic [31:0] wr_word;
  logic [31:0] mem [DEPTH];

  assign ld_ready_o = (state_q == ST_LOAD);
  assign accept     = ld_valid_i & ld_ready_o;
  assign word_wr    = accept & ((byte_cnt_q == 2'd3) | ld_last_i);
  // A word arriving once the array is full is dropped and flagged instead of wrapping.
  assign mem_we     = word_wr & (word_idx_q < DEPTH_W);

  // Lanes above the current byte are zero, so a short final word is zero-padded.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    wr_word = '0;
    case (byte_cnt_q)
      2'd0:    wr_word = {24'h0, ld_byte_i};
      2'd1:    wr_word = {16'h0, ld_byte_i, shift_q[7:0]};
      2'd2:    wr_word = {8'h0, ld_byte_i, shift_q[15:0]};
      default: wr_word = {ld_byte_i, shift_q};
    endcase
  end

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    word_idx_d   = word_idx_q;
    shift_d      = shift_q;
    core_rst_n_d = core_rst_n_q;
    load_done_d  = load_done_q;
    ovf_d        = ovf_q;
    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          if (word_wr) begin
            byte_cnt_d = 2'd0;
            shift_d    = '0;
            if (mem_we) word_idx_d = word_idx_q + (AW+1)'(1);
            else        ovf_d      = 1'b1;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            case (byte_cnt_q)
              2'd0:    shift_d[7:0]   = ld_byte_i;
              2'd1:    shift_d[15:8]  = ld_byte_i;
              default: shift_d[23:16] = ld_byte_i;
            endcase
          end
          if (ld_last_i) state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        state_d      = ST_RUN;
        core_rst_n_d = 1'b1;
        load_done_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_LOAD;
      byte_cnt_q   <= 2'd0;
      word_idx_q   <= '0;
      shift_q      <= '0;
      core_rst_n_q <= 1'b0;
      load_done_q  <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      word_idx_q   <= word_idx_d;
      shift_q      <= shift_d;
      core_rst_n_q <= core_rst_n_d;
      load_done_q  <= load_done_d;
      ovf_q        <= ovf_d;
    end
  end

  // NOTE: the array has no reset; contents survive rst_n and are simply overwritten by the next image.
  always_ff @(posedge clk) begin
    if (mem_we) mem[word_idx_q[AW-1:0]] <= wr_word;
  end

  always_comb begin
    rom_data_o = NOP;
    if ((state_q == ST_RUN) && rom_ce_i && (rom_addr_i < ADDR_LIMIT))
      rom_data_o = mem[rom_addr_i[AW+1:2]];
  end

  assign core_rst_n_o = core_rst_n_q;
  assign load_done_o  = load_done_q;
  assign ovf_o        = ovf_q;
  assign words_o      = word_idx_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Scoreboard bench for inst_rom_loader: a byte-image reference model predicts memory
// contents and status; a negedge monitor drains the expectation queue against the DUT.
module tb_inst_rom_loader;

  localparam int          DEPTH = 16;
  localparam int          AW    = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        rom_ce_i;
  logic [31:0] rom_addr_i;
  logic [31:0] rom_data_o;
  logic        ld_valid_i;
  logic [7:0]  ld_byte_i;
  logic        ld_last_i;
  logic        ld_ready_o;
  logic        core_rst_n_o;
  logic        load_done_o;
  logic        ovf_o;
  logic [AW:0] words_o;

  inst_rom_loader #(.DEPTH(DEPTH), .AW(AW), .NOP(NOP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rom_ce_i     (rom_ce_i),
    .rom_addr_i   (rom_addr_i),
    .rom_data_o   (rom_data_o),
    .ld_valid_i   (ld_valid_i),
    .ld_byte_i    (ld_byte_i),
    .ld_last_i    (ld_last_i),
    .ld_ready_o   (ld_ready_o),
    .core_rst_n_o (core_rst_n_o),
    .load_done_o  (load_done_o),
    .ovf_o        (ovf_o),
    .words_o      (words_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_fetch;
    logic [31:0] data;
    logic [AW:0] words;
    logic        ovf;
    logic        done;
    logic        crst;
    logic        rdy;
  } exp_t;

  exp_t        exp_q[$];
  string       name_q[$];
  int          checks   = 0;
  int          failures = 0;

  // Reference model: memory image as the core should see it, plus expected status.
  logic [31:0] mem_m [DEPTH];
  bit          written_m [DEPTH];
  int          words_m;
  bit          ovf_m;
  logic [7:0]  img_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t  e;
    string n;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      if (e.is_fetch) begin
        check(n, rom_data_o, e.data);
      end else begin
        check({n, ".words"},      32'(words_o),      32'(e.words));
        check({n, ".ovf"},        32'(ovf_o),        32'(e.ovf));
        check({n, ".load_done"},  32'(load_done_o),  32'(e.done));
        check({n, ".core_rst_n"}, 32'(core_rst_n_o), 32'(e.crst));
        check({n, ".ld_ready"},   32'(ld_ready_o),   32'(e.rdy));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_status(input string n, input bit crst, input bit done, input bit rdy);
    exp_t e;
    e       = '0;
    e.words = (AW+1)'(words_m);
    e.ovf   = ovf_m;
    e.done  = done;
    e.crst  = crst;
    e.rdy   = rdy;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic exp_fetch(input string n, input logic ce, input logic [31:0] addr,
                           input logic [31:0] data);
    exp_t e;
    rom_ce_i   = ce;
    rom_addr_i = addr;
    e          = '0;
    e.is_fetch = 1'b1;
    e.data     = data;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  // Image -> words: word k holds bytes 4k..4k+3 little-endian, missing bytes zero;
  // only the first DEPTH words land, anything beyond sets overflow.
  task automatic model_load();
    int n;
    n = (img_q.size() + 3) / 4;
    for (int k = 0; k < n && k < DEPTH; k++) begin
      logic [31:0] w;
      w = 32'h0;
      for (int j = 0; j < 4; j++)
        if (4 * k + j < img_q.size()) w = w | (32'(img_q[4 * k + j]) << (8 * j));
      mem_m[k]     = w;
      written_m[k] = 1'b1;
    end
    words_m = (n < DEPTH) ? n : DEPTH;
    ovf_m   = (n > DEPTH);
  endtask

  task automatic do_reset();
    tick();
    rst_n      = 1'b0;
    ld_valid_i = 1'b0;
    ld_last_i  = 1'b0;
    rom_ce_i   = 1'b0;
    words_m    = 0;
    ovf_m      = 1'b0;
    exp_status("in_reset", 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    rst_n = 1'b1;
    exp_status("after_reset", 1'b0, 1'b0, 1'b1);
    exp_fetch("fetch_before_load", 1'b1, 32'h0, NOP);
    tick();
    rom_ce_i = 1'b0;
  endtask

  // gap_mode: 0 continuous, 1 valid toggles every other cycle, 2 random idle gaps.
  task automatic send_byte(input logic [7:0] b, input bit last, input int gap_mode, input string tag);
    int n;
    if (gap_mode == 1) tick();
    else if (gap_mode == 2) repeat ($urandom_range(0, 3)) tick();
    ld_valid_i = 1'b1;
    ld_byte_i  = b;
    ld_last_i  = last;
    n = 0;
    while (!ld_ready_o && n < 8) begin
      tick();
      n++;
    end
    check({tag, ".ld_ready_wait"}, 32'(ld_ready_o), 32'd1);
    tick();
    ld_valid_i = 1'b0;
    ld_last_i  = 1'($urandom_range(0, 1));
    ld_byte_i  = 8'($urandom);
  endtask

  task automatic load_image(input int gap_mode, input string tag);
    for (int i = 0; i < img_q.size(); i++) begin
      if (i == 0) exp_status({tag, ".loading"}, 1'b0, 1'b0, 1'b1);
      send_byte(img_q[i], (i == img_q.size() - 1), gap_mode, tag);
    end
    ld_last_i = 1'b0;
    model_load();
    exp_status({tag, ".commit"}, 1'b0, 1'b0, 1'b0);
    tick();
    exp_status({tag, ".run"}, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic fetch_all(input string tag);
    for (int k = 0; k < DEPTH; k++) begin
      if (written_m[k]) begin
        tick();
        exp_fetch($sformatf("%s.fetch_w%0d", tag, k), 1'b1,
                  32'(4 * k) + 32'($urandom_range(0, 3)), mem_m[k]);
      end
    end
    tick();
    exp_fetch({tag, ".fetch_at_limit"}, 1'b1, 32'(DEPTH * 4), NOP);
    tick();
    exp_fetch({tag, ".fetch_beyond"}, 1'b1, 32'(DEPTH * 4) + 32'($urandom_range(1, 4000)), NOP);
    tick();
    exp_fetch({tag, ".fetch_ce_low"}, 1'b0, 32'h4, NOP);
    tick();
    rom_ce_i = 1'b0;
  endtask

  task automatic rand_image(input int len);
    img_q.delete();
    for (int i = 0; i < len; i++) img_q.push_back(8'($urandom));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    rom_ce_i   = 1'b0;
    rom_addr_i = 32'h0;
    ld_valid_i = 1'b0;
    ld_byte_i  = 8'h0;
    ld_last_i  = 1'b0;
    for (int k = 0; k < DEPTH; k++) written_m[k] = 1'b0;

    do_reset();
    img_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    load_image(0, "boot8");
    fetch_all("boot8");
    // Loader inputs are ignored once running.
    for (int i = 0; i < 4; i++) begin
      ld_valid_i = 1'b1;
      ld_byte_i  = 8'($urandom);
      ld_last_i  = 1'($urandom_range(0, 1));
      exp_status($sformatf("run_ignore_%0d", i), 1'b1, 1'b1, 1'b0);
      tick();
    end
    ld_valid_i = 1'b0;
    fetch_all("run_ignore");

    do_reset();
    img_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    load_image(1, "six_toggle");
    fetch_all("six_toggle");

    do_reset();
    img_q = '{8'h5A};
    load_image(0, "one_byte");
    fetch_all("one_byte");

    for (int r = 0; r < 4; r++) begin
      do_reset();
      rand_image($urandom_range(1, 40));
      load_image($urandom_range(0, 2), $sformatf("rand%0d", r));
      fetch_all($sformatf("rand%0d", r));
    end

    do_reset();
    rand_image(DEPTH * 4 + 5);
    load_image(2, "overflow");
    fetch_all("overflow");

    // Reset in the middle of a word: the partial word must not appear anywhere.
    do_reset();
    send_byte(8'hEE, 1'b0, 0, "partial");
    send_byte(8'hEF, 1'b0, 0, "partial");
    send_byte(8'hF0, 1'b0, 0, "partial");
    exp_status("partial_before_pulse", 1'b0, 1'b0, 1'b1);
    do_reset();
    img_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    load_image(0, "reload");
    fetch_all("reload");

    repeat (2) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
